alu_arbiter: RTL

- Shares one `alu` instance between NUM_REQ requesters, e.g. the main execute path and a branch/address helper.
- Each requester has a valid/ready handshake. The arbiter grants one requester per cycle in round-robin order.
- The granted operands go through the ALU, and the result is registered back to the winner one cycle later.
- Sits in the execute stage in front of the single ALU datapath.

---
 rtl/alu_arb_pkg.sv | 51 +++++
 rtl/alu_arbiter_alu.sv | 43 ++++
 rtl/alu_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/alu_arb_pkg.sv
// Purpose: shared types and helpers for the round-robin ALU arbiter (opcodes, shift width, grant picker).
// Latency: n/a (types and pure combinational function only).
// Backpressure: n/a.
package alu_arb_pkg;

    // ALU operation encodings; any other code yields a zero result.
    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_SUB = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_OR  = 4'b0011,
        ALU_XOR = 4'b0100,
        ALU_SLT = 4'b0101,
        ALU_EQ  = 4'b1000,
        ALU_SLL = 4'b1001,
        ALU_SRL = 4'b1010,
        ALU_SRA = 4'b1011
    } alu_op_e;

    localparam int ALU_SHAMT_W = 5;

    // Widest requester count the picker supports; narrower arbiters zero-extend.
    localparam int RR_MAX = 8;

    // Round-robin pick: scan from ptr upward modulo num, first valid wins.
    // Returns a one-hot (or all-zero) grant vector.
    function automatic logic [RR_MAX-1:0] rr_pick(
        input logic [RR_MAX-1:0] valid,
        input logic [2:0]        ptr,
        input int unsigned       num
    );
        logic [RR_MAX-1:0] grant;
        logic              found;
        int unsigned       idx;
        logic [2:0]        sel;
        grant = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < RR_MAX; k++) begin
            if (k < num) begin
                idx = (32'(ptr) + k) % num;
                sel = 3'(idx);
                if (!found && valid[sel]) begin
                    grant[sel] = 1'b1;
                    found      = 1'b1;
                end
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Purpose: single-cycle integer ALU (logic, add/sub, signed compare, equality, shifts).
// Latency: purely combinational.
// Backpressure: none.
// Ports: srca/srcb operands, op operation code, result.
module alu
    import alu_arb_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic [DATA_WIDTH-1:0]    srca,
    input  logic [DATA_WIDTH-1:0]    srcb,
    input  logic [OPCODE_LENGTH-1:0] op,
    output logic [DATA_WIDTH-1:0]    result
);

    logic [ALU_SHAMT_W-1:0] shamt;
    logic                   slt_bit;
    logic                   eq_bit;

    // Shift amount only ever uses the low bits of SrcB; upper bits are ignored.
    assign shamt   = srcb[ALU_SHAMT_W-1:0];
    assign slt_bit = ($signed(srca) < $signed(srcb));
    assign eq_bit  = (srca == srcb);

    always_comb begin
        result = '0;
        case (op)
            ALU_AND: result = srca & srcb;
            ALU_SUB: result = srca - srcb;
            ALU_ADD: result = srca + srcb;
            ALU_OR:  result = srca | srcb;
            ALU_XOR: result = srca ^ srcb;
            ALU_SLT: result = {{(DATA_WIDTH-1){1'b0}}, slt_bit};
            ALU_EQ:  result = {{(DATA_WIDTH-1){1'b0}}, eq_bit};
            ALU_SLL: result = srca << shamt;
            ALU_SRL: result = srca >> shamt;
            ALU_SRA: result = DATA_WIDTH'($signed(srca) >>> shamt);
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Purpose: round-robin arbiter sharing one ALU among NUM_REQ requesters; optional per-requester grant counters (ALU_ARB_STATS_EN).
// Latency: result and one-hot rsp_valid registered exactly 1 cycle after the grant; 1 op/cycle throughput.
// Backpressure: requesters wait on combinational one-hot req_ready; the response path has no backpressure.
// Ports: clk, reset (sync, active-high), flush, req_valid/req_ready, packed req_srca/req_srcb/req_op,
//        rsp_valid (one-hot strobe), rsp_result, busy, grant_count (only with ALU_ARB_STATS_EN).
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4,
    parameter int NUM_REQ       = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             flush,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_srca,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_srcb,
    input  logic [NUM_REQ*OPCODE_LENGTH-1:0] req_op,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_result,
`ifdef ALU_ARB_STATS_EN
    output logic [NUM_REQ*32-1:0]            grant_count,
`endif
    output logic                             busy
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0]         rr_ptr;
    logic [IDX_W-1:0]         next_ptr;
    logic [RR_MAX-1:0]        pick;
    logic [NUM_REQ-1:0]       grant;
    logic                     transfer;
    logic [DATA_WIDTH-1:0]    alu_srca;
    logic [DATA_WIDTH-1:0]    alu_srcb;
    logic [OPCODE_LENGTH-1:0] alu_op;
    logic [DATA_WIDTH-1:0]    alu_result;

    assign pick  = rr_pick(RR_MAX'(req_valid), 3'(rr_ptr), NUM_REQ);
    assign grant = pick[NUM_REQ-1:0];

    generate
        if (NUM_REQ < RR_MAX) begin : g_pick_unused
            logic unused_pick_hi;
            assign unused_pick_hi = |pick[RR_MAX-1:NUM_REQ];
        end
    endgenerate

    // Reset masks the grant so nothing is consumed while the block is held.
    assign req_ready = reset ? '0 : grant;
    assign transfer  = |req_ready;

    // Operand mux and next pointer both follow the one-hot grant.
    always_comb begin
        alu_srca = '0;
        alu_srcb = '0;
        alu_op   = '0;
        next_ptr = rr_ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                alu_srca = req_srca[i*DATA_WIDTH +: DATA_WIDTH];
                alu_srcb = req_srcb[i*DATA_WIDTH +: DATA_WIDTH];
                alu_op   = req_op[i*OPCODE_LENGTH +: OPCODE_LENGTH];
                next_ptr = (i == NUM_REQ-1) ? '0 : IDX_W'(i + 1);
            end
        end
    end

    alu #(
        .DATA_WIDTH    (DATA_WIDTH),
        .OPCODE_LENGTH (OPCODE_LENGTH)
    ) u_alu (
        .srca   (alu_srca),
        .srcb   (alu_srcb),
        .op     (alu_op),
        .result (alu_result)
    );

    // A flushed transfer still consumes the request and moves the pointer,
    // but its result is dropped: no strobe and rsp_result keeps its old value.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr     <= '0;
            rsp_valid  <= '0;
            rsp_result <= '0;
        end else begin
            rsp_valid <= flush ? '0 : req_ready;
            if (transfer) begin
                rr_ptr <= next_ptr;
                if (!flush) begin
                    rsp_result <= alu_result;
                end
            end
        end
    end

    assign busy = (|req_valid) | (|rsp_valid);

`ifdef ALU_ARB_STATS_EN
    logic [31:0] grant_cnt [NUM_REQ];

    // Saturating per-requester grant counters; flush does not clear them.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                grant_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i] && (grant_cnt[i] != 32'hFFFF_FFFF)) begin
                    grant_cnt[i] <= grant_cnt[i] + 32'd1;
                end
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt_out
            assign grant_count[g*32 +: 32] = grant_cnt[g];
        end
    endgenerate
`endif

    a_ready_onehot0: assert property (@(posedge clk) $onehot0(req_ready));
    a_rsp_onehot0:   assert property (@(posedge clk) $onehot0(rsp_valid));

    generate
        for (genvar g = 0; g < NUM_REQ; g++) begin : g_rsp_origin
            a_rsp_origin: assert property (@(posedge clk)
                rsp_valid[g] |-> $past(req_ready[g] && !flush && !reset));
        end
    endgenerate

endmodule
